// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: picks one eligible slave channel per packet (programmable
// priority, round-robin tie-break), pops the whole packet from that slave and
// presents it on a registered valid/ready stream tagged with channel id and
// start/end-of-packet markers.
// Optional build macro ARB_PARITY_GEN_EN adds data_p_o, an even-parity bit
// registered alongside data_o so that ^{data_o, data_p_o} == 0.
module mcdf_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 32,
  parameter int DW         = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH*DW-1:0] slv_data_i,
  input  logic [NUM_CH-1:0]    slv_valid_i,
  input  logic [NUM_CH*6-1:0]  slv_freeslot_i,
  output logic [NUM_CH-1:0]    slv_fetch_o,
  input  logic [NUM_CH-1:0]    slv_en_i,
  input  logic [NUM_CH*2-1:0]  slv_prio_i,
  input  logic [NUM_CH*2-1:0]  pkt_len_i,
  output logic [DW-1:0]        data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sof_o,
  output logic                 eof_o,
  output logic [1:0]           ch_id_o,
  output logic                 busy_o
`ifdef ARB_PARITY_GEN_EN
  ,
  output logic                 data_p_o
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ch;
  logic [5:0]  r_len;
  logic [5:0]  r_cnt;
  logic [1:0]  r_last;

  logic [6:0]        w_avail [NUM_CH];
  logic [NUM_CH-1:0] w_elig;
  logic              w_any;
  logic [1:0]        w_sel;
  logic [1:0]        w_min;
  logic              w_fetch;
  logic [DW-1:0]     w_head;

  // Length code to packet length in words: 4, 8, 16 or 32.
  function automatic logic [5:0] f_len(input logic [1:0] code);
    f_len = 6'(6'd4 << code);
  endfunction

`ifdef ARB_PARITY_GEN_EN
  // Even parity: returns the bit that makes the total count of ones even.
  function automatic logic f_even_par(input logic [DW-1:0] d);
    f_even_par = ^d;
  endfunction
`endif

  // Per-channel eligibility: enabled and holding at least one full packet.
  always_comb begin
    w_elig = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_avail[n] = 7'(FIFO_DEPTH) - {1'b0, slv_freeslot_i[n*6 +: 6]};
      if (slv_en_i[n] && ({1'b0, slv_freeslot_i[n*6 +: 6]} <= 7'(FIFO_DEPTH))
          && (w_avail[n] >= {1'b0, f_len(pkt_len_i[n*2 +: 2])})) begin
        w_elig[n] = 1'b1;
      end else begin
        w_elig[n] = 1'b0;
      end
    end
  end

  // Winner selection: lowest prio value, ties broken from last grant + 1.
  always_comb begin
    logic found;
    int   idx;
    w_any = |w_elig;
    w_min = 2'd3;
    w_sel = 2'd0;
    found = 1'b0;
    idx   = 0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_elig[n] && (slv_prio_i[n*2 +: 2] < w_min)) begin
        w_min = slv_prio_i[n*2 +: 2];
      end else begin
        w_min = w_min;
      end
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(r_last) + k) % NUM_CH;
      if (!found && w_elig[idx] && (slv_prio_i[idx*2 +: 2] == w_min)) begin
        w_sel = 2'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Pop decision for the granted channel; stalls on empty slave or full output.
  always_comb begin
    w_head  = slv_data_i[r_ch*DW +: DW];
    w_fetch = (r_state == S_XFER) && (r_cnt < r_len) && slv_valid_i[r_ch]
              && (!valid_o || ready_i);
    slv_fetch_o = '0;
    if (w_fetch) begin
      slv_fetch_o[r_ch] = 1'b1;
    end else begin
      slv_fetch_o = '0;
    end
  end

  // Arbitration/transfer FSM with all stream outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_ch     <= 2'd0;
      r_len    <= 6'd0;
      r_cnt    <= 6'd0;
      r_last   <= 2'(NUM_CH - 1);
      data_o   <= '0;
      valid_o  <= 1'b0;
      sof_o    <= 1'b0;
      eof_o    <= 1'b0;
      ch_id_o  <= 2'd0;
      busy_o   <= 1'b0;
`ifdef ARB_PARITY_GEN_EN
      data_p_o <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ch    <= w_sel;
            r_len   <= f_len(pkt_len_i[w_sel*2 +: 2]);
            r_cnt   <= 6'd0;
            r_last  <= w_sel;
            r_state <= S_XFER;
            busy_o  <= 1'b1;
          end
        end
        S_XFER: begin
          if (w_fetch) begin
            data_o   <= w_head;
            valid_o  <= 1'b1;
            sof_o    <= (r_cnt == 6'd0);
            eof_o    <= (r_cnt == (r_len - 6'd1));
            ch_id_o  <= r_ch;
            r_cnt    <= r_cnt + 6'd1;
`ifdef ARB_PARITY_GEN_EN
            data_p_o <= f_even_par(w_head);
`endif
          end else if (ready_i && valid_o) begin
            valid_o <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
          end
          // Packet ends when its last word is taken downstream.
          if (valid_o && eof_o && ready_i) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: behavioural slave FIFOs, a
// scoreboard of expected stream words, and a negedge output monitor.
module tb_mcdf_arbiter;
  localparam int NCH = 3;
  localparam int DW  = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH*DW-1:0] slv_data_i;
  logic [NCH-1:0]    slv_valid_i;
  logic [NCH*6-1:0]  slv_freeslot_i;
  logic [NCH-1:0]    slv_fetch_o;
  logic [NCH-1:0]    slv_en_i;
  logic [NCH*2-1:0]  slv_prio_i;
  logic [NCH*2-1:0]  pkt_len_i;
  logic [DW-1:0]     data_o;
  logic              valid_o;
  logic              ready_i;
  logic              sof_o;
  logic              eof_o;
  logic [1:0]        ch_id_o;
  logic              busy_o;
`ifdef ARB_PARITY_GEN_EN
  logic              data_p_o;
`endif

  mcdf_arbiter #(.NUM_CH(NCH), .FIFO_DEPTH(32), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_data_i(slv_data_i), .slv_valid_i(slv_valid_i),
    .slv_freeslot_i(slv_freeslot_i), .slv_fetch_o(slv_fetch_o),
    .slv_en_i(slv_en_i), .slv_prio_i(slv_prio_i), .pkt_len_i(pkt_len_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sof_o(sof_o), .eof_o(eof_o), .ch_id_o(ch_id_o), .busy_o(busy_o)
`ifdef ARB_PARITY_GEN_EN
    , .data_p_o(data_p_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sq[NCH][$];
  logic [31:0] pend[NCH][$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          seq = 0;
  int          cyc = 0;
  int          last_eof_cyc = -100;
  logic [2:0]  fetch_seen = 3'd0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b1;
  logic [31:0] p_data = 32'd0;
  logic        p_sof = 1'b0;
  logic        p_eof = 1'b0;
  logic [1:0]  p_ch = 2'd0;
  exp_t        m_e;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Drive slave-side inputs from the behavioural FIFO contents.
  task automatic refresh();
    for (int c = 0; c < NCH; c++) begin
      slv_valid_i[c]             = (sq[c].size() != 0);
      slv_data_i[c*DW +: DW]     = (sq[c].size() != 0) ? sq[c][0] : 32'd0;
      slv_freeslot_i[c*6 +: 6]   = 6'(32 - sq[c].size());
    end
  endtask

  task automatic push_word(input int ch, input logic [31:0] d);
    sq[ch].push_back(d);
    pend[ch].push_back(d);
    refresh();
  endtask

  task automatic push_seq(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      push_word(ch, {6'(ch), 26'(seq)});
      seq++;
    end
  endtask

  // Queue the first n words of a len-word packet from channel ch.
  task automatic expect_pkt(input int ch, input int len, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ch  = 2'(ch);
      e.d   = pend[ch].pop_front();
      e.sof = (i == 0);
      e.eof = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: slaves pop what was fetched at the edge, then inputs settle.
  task automatic tick();
    logic [31:0] tmp;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (fetch_seen[c] && (sq[c].size() != 0)) tmp = sq[c].pop_front();
    end
    refresh();
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && !(exp_q.size() == 0 && !busy_o); i++) tick();
    chk(tag, 64'(exp_q.size() == 0 && !busy_o), 64'd1);
  endtask

  // Output monitor: scoreboard compare, hold-under-backpressure, fetch rules.
  always @(negedge clk_i) begin
    cyc++;
    fetch_seen = slv_fetch_o;
    chk("fetch_onehot", 64'($countones(slv_fetch_o) <= 1), 64'd1);
    if (valid_o && !ready_i) chk("stall_no_fetch", 64'(slv_fetch_o), 64'd0);
    if (p_valid && !p_ready) begin
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_data", 64'(data_o), 64'(p_data));
      chk("hold_marks", 64'({sof_o, eof_o, ch_id_o}), 64'({p_sof, p_eof, p_ch}));
    end
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", 64'(valid_o), 64'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("word_data", 64'(data_o), 64'(m_e.d));
        chk("word_sof", 64'(sof_o), 64'(m_e.sof));
        chk("word_eof", 64'(eof_o), 64'(m_e.eof));
        chk("word_ch", 64'(ch_id_o), 64'(m_e.ch));
        if (sof_o) chk("bubble", 64'((cyc - last_eof_cyc) >= 2), 64'd1);
        if (eof_o) last_eof_cyc = cyc;
      end
    end
`ifdef ARB_PARITY_GEN_EN
    if (valid_o) chk("parity", 64'(^{data_o, data_p_o}), 64'd0);
`endif
    p_valid = valid_o;
    p_ready = ready_i;
    p_data  = data_o;
    p_sof   = sof_o;
    p_eof   = eof_o;
    p_ch    = ch_id_o;
  end

  initial begin
    rst_i      = 1'b1;
    ready_i    = 1'b1;
    slv_en_i   = 3'b000;
    slv_prio_i = 6'd0;
    pkt_len_i  = 6'd0;
    slv_data_i = '0;
    slv_valid_i = '0;
    slv_freeslot_i = '0;
    refresh();
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_marks", 64'({sof_o, eof_o, ch_id_o, busy_o}), 64'd0);
    chk("rst_fetch", 64'(slv_fetch_o), 64'd0);
`ifdef ARB_PARITY_GEN_EN
    chk("rst_parity", 64'(data_p_o), 64'd0);
`endif
    rst_i = 1'b0;

    // Single channel, 4-word packet.
    slv_en_i = 3'b001;
    push_seq(0, 4);
    expect_pkt(0, 4, 4);
    tick();
    chk("t1_grant_busy", 64'(busy_o), 64'd1);
    chk("t1_no_valid_at_grant", 64'(valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_fetch", 64'(slv_fetch_o), 64'd1);
      tick();
    end
    chk("t1_fetch_done", 64'(slv_fetch_o), 64'd0);
    chk("t1_eof", 64'({valid_o, eof_o}), 64'd3);
    drain("t1_drain");
    chk("t1_idle", 64'(busy_o), 64'd0);

    // Priority: ch2 (prio 0) before ch0 (prio 2), 8-word packets.
    slv_en_i   = 3'b101;
    slv_prio_i = {2'd0, 2'd0, 2'd2};
    pkt_len_i  = {2'd1, 2'd0, 2'd1};
    push_seq(0, 8);
    push_seq(2, 8);
    expect_pkt(2, 8, 8);
    expect_pkt(0, 8, 8);
    drain("t2_drain");

    // Round-robin tie from a fresh pointer: ch0, ch1, ch2, ch0.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    slv_en_i   = 3'b111;
    slv_prio_i = {2'd1, 2'd1, 2'd1};
    pkt_len_i  = 6'd0;
    push_seq(0, 8);
    push_seq(1, 4);
    push_seq(2, 4);
    expect_pkt(0, 4, 4);
    expect_pkt(1, 4, 4);
    expect_pkt(2, 4, 4);
    expect_pkt(0, 4, 4);
    drain("t3_drain");

    // Backpressure mid-packet.
    slv_en_i  = 3'b001;
    pkt_len_i = {2'd0, 2'd0, 2'd1};
    push_seq(0, 8);
    expect_pkt(0, 8, 8);
    for (int i = 0; i < 4; i++) tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_fetch", 64'(slv_fetch_o), 64'd0);
      chk("t4_stall_valid", 64'(valid_o), 64'd1);
    end
    ready_i = 1'b1;
    drain("t4_drain");

    // Under-threshold: 15 of 16 words is not enough.
    slv_en_i  = 3'b010;
    pkt_len_i = {2'd0, 2'd2, 2'd0};
    push_seq(1, 15);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_grant", 64'(busy_o), 64'd0);
    end
    push_seq(1, 1);
    expect_pkt(1, 16, 16);
    tick();
    chk("t5_grant", 64'(busy_o), 64'd1);
    drain("t5_drain");

    // Reset while word 2 of an 8-word packet is on the output.
    slv_en_i  = 3'b001;
    pkt_len_i = {2'd0, 2'd0, 2'd1};
    push_seq(0, 8);
    expect_pkt(0, 8, 3);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_word2_valid", 64'(valid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(valid_o), 64'd0);
    chk("t6_rst_data", 64'(data_o), 64'd0);
    chk("t6_rst_marks", 64'({sof_o, eof_o, ch_id_o, busy_o}), 64'd0);
    rst_i = 1'b0;
    slv_en_i = 3'b000;
    sq[0].delete();
    pend[0].delete();
    refresh();
    tick();
    chk("t6_no_more_words", 64'(exp_q.size()), 64'd0);
    chk("t6_idle", 64'(busy_o), 64'd0);

    // Parity-sensitive data patterns.
    slv_en_i  = 3'b001;
    pkt_len_i = 6'd0;
    push_word(0, 32'h0000_0001);
    push_word(0, 32'h0000_0003);
    push_word(0, 32'h0000_0007);
    push_word(0, 32'hFFFF_FFFF);
    expect_pkt(0, 4, 4);
    drain("t7_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
